// File: rtl/score_keeper.sv
// score_keeper: BCD score, lives, best score and idle/play/over phase machine for the memory game.
module score_keeper #(
  parameter int MAX_LIVES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_game,
  input  logic        inc_point,
  input  logic        dec_point,
  output logic [11:0] score_bcd,
  output logic [11:0] best_bcd,
  output logic [3:0]  lives,
  output logic [1:0]  phase,
  output logic        new_best
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} phase_t;
  phase_t state, state_n;
  logic [2:0] prev;
  logic ng_ev, inc_ev, dec_ev;
  logic [11:0] score_n, best_n, score_inc;
  logic [3:0] lives_n;
  logic new_best_n;
  assign {ng_ev, inc_ev, dec_ev} = {new_game, inc_point, dec_point} & ~prev;
  assign phase = state;
  // Saturating BCD increment; 999 is the only value with hundreds at 9 and both lower digits at 9.
  always_comb begin
    score_inc = score_bcd;
    if (score_bcd != 12'h999) begin
      if (score_bcd[3:0] != 4'd9) score_inc[3:0] = score_bcd[3:0] + 4'd1;
      else begin
        score_inc[3:0] = 4'd0;
        if (score_bcd[7:4] != 4'd9) score_inc[7:4] = score_bcd[7:4] + 4'd1;
        else begin
          score_inc[7:4] = 4'd0;
          score_inc[11:8] = score_bcd[11:8] + 4'd1;
        end
      end
    end
  end
  always_comb begin
    state_n = state;
    score_n = score_bcd;
    lives_n = lives;
    best_n = best_bcd;
    new_best_n = 1'b0;
    if (ng_ev) begin
      state_n = PLAY;
      score_n = 12'h000;
      lives_n = 4'(MAX_LIVES);
    end else if (state == PLAY) begin
      score_n = inc_ev ? score_inc : score_bcd;
      lives_n = (dec_ev && lives != 4'd0) ? lives - 4'd1 : lives;
      if (lives_n == 4'd0) begin
        state_n = OVER;
        if (score_n > best_bcd) begin
          best_n = score_n;
          new_best_n = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      prev <= 3'b111;
      score_bcd <= 12'h000;
      best_bcd <= 12'h000;
      lives <= 4'd0;
      new_best <= 1'b0;
    end else begin
      state <= state_n;
      prev <= {new_game, inc_point, dec_point};
      score_bcd <= score_n;
      best_bcd <= best_n;
      lives <= lives_n;
      new_best <= new_best_n;
    end
  end
endmodule
